// File: rtl/key_conditioner.sv
// Debounces the active-low push buttons and turns each accepted key into a clean level
// plus press / release / auto-repeat pulses, one independent channel per key.
module key_conditioner #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_n,
    input  logic                repeat_en,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_repeat,
    output logic                any_press
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX) + 1;

    localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_MAX   = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_RELEASED    = 2'd0,
        ST_HELD_WAIT   = 2'd1,
        ST_HELD_REPEAT = 2'd2
    } state_t;

    logic [NUM_KEYS-1:0] sync1_r;
    logic [NUM_KEYS-1:0] sync2_r;
    logic [NUM_KEYS-1:0] pressed_s;
    logic [NUM_KEYS-1:0] press_nxt_s;
    logic                any_press_r;

    // Two-flop synchronizer; resets to the released (high) level so no phantom press appears.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= '1;
            sync2_r <= '1;
        end else begin
            sync1_r <= key_n;
            sync2_r <= sync1_r;
        end
    end

    assign pressed_s = ~sync2_r;

    // any_press is registered from the same next-cycle press terms so it lines up with key_press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            any_press_r <= 1'b0;
        end else begin
            any_press_r <= |press_nxt_s;
        end
    end

    assign any_press = any_press_r;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        logic [DW-1:0] deb_cnt_r;
        logic [DW-1:0] deb_cnt_nxt_s;
        logic          level_r;
        logic          accept_s;
        state_t        state_r;
        state_t        state_nxt_s;
        logic [RW-1:0] rep_cnt_r;
        logic [RW-1:0] rep_cnt_nxt_s;
        logic          press_r;
        logic          release_r;
        logic          repeat_r;
        logic          press_s;
        logic          release_s;
        logic          repeat_s;

        // State register: debounce, FSM, repeat counter and the registered pulses.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                deb_cnt_r <= '0;
                level_r   <= 1'b0;
                state_r   <= ST_RELEASED;
                rep_cnt_r <= '0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
                repeat_r  <= 1'b0;
            end else begin
                deb_cnt_r <= deb_cnt_nxt_s;
                level_r   <= level_r ^ accept_s;
                state_r   <= state_nxt_s;
                rep_cnt_r <= rep_cnt_nxt_s;
                press_r   <= press_s;
                release_r <= release_s;
                repeat_r  <= repeat_s;
            end
        end

        // Debounce: a level change is accepted on the edge the stable run would reach its target.
        always_comb begin
            deb_cnt_nxt_s = '0;
            accept_s      = 1'b0;
            if (pressed_s[k] != level_r) begin
                if (deb_cnt_r == DEB_LAST) begin
                    accept_s = 1'b1;
                end else begin
                    deb_cnt_nxt_s = deb_cnt_r + DW'(1);
                end
            end else begin
                deb_cnt_nxt_s = '0;
            end
        end

        // Next-state: an accepted release always wins over any repeat activity.
        always_comb begin
            state_nxt_s   = state_r;
            rep_cnt_nxt_s = rep_cnt_r;
            case (state_r)
                ST_RELEASED: begin
                    if (accept_s) begin
                        state_nxt_s   = ST_HELD_WAIT;
                        rep_cnt_nxt_s = '0;
                    end else begin
                        rep_cnt_nxt_s = '0;
                    end
                end
                ST_HELD_WAIT: begin
                    if (accept_s) begin
                        state_nxt_s   = ST_RELEASED;
                        rep_cnt_nxt_s = '0;
                    end else if (repeat_en && (rep_cnt_r >= DELAY_LAST)) begin
                        state_nxt_s   = ST_HELD_REPEAT;
                        rep_cnt_nxt_s = '0;
                    end else if (rep_cnt_r < DELAY_MAX) begin
                        rep_cnt_nxt_s = rep_cnt_r + RW'(1);
                    end else begin
                        rep_cnt_nxt_s = rep_cnt_r;
                    end
                end
                ST_HELD_REPEAT: begin
                    if (accept_s) begin
                        state_nxt_s   = ST_RELEASED;
                        rep_cnt_nxt_s = '0;
                    end else if (!repeat_en) begin
                        rep_cnt_nxt_s = rep_cnt_r;
                    end else if (rep_cnt_r >= PERIOD_LAST) begin
                        rep_cnt_nxt_s = '0;
                    end else begin
                        rep_cnt_nxt_s = rep_cnt_r + RW'(1);
                    end
                end
                default: begin
                    state_nxt_s   = ST_RELEASED;
                    rep_cnt_nxt_s = '0;
                end
            endcase
        end

        // Output decode; these terms are registered so pulses align with the key_level edge.
        always_comb begin
            press_s   = 1'b0;
            release_s = 1'b0;
            repeat_s  = 1'b0;
            case (state_r)
                ST_RELEASED: begin
                    press_s = accept_s;
                end
                ST_HELD_WAIT: begin
                    release_s = accept_s;
                    repeat_s  = !accept_s && repeat_en && (rep_cnt_r >= DELAY_LAST);
                end
                ST_HELD_REPEAT: begin
                    release_s = accept_s;
                    repeat_s  = !accept_s && repeat_en && (rep_cnt_r >= PERIOD_LAST);
                end
                default: begin
                    press_s = 1'b0;
                end
            endcase
        end

        assign press_nxt_s[k] = press_s;
        assign key_level[k]   = level_r;
        assign key_press[k]   = press_r;
        assign key_release[k] = release_r;
        assign key_repeat[k]  = repeat_r;
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with short debounce/repeat timings.
module tb_key_conditioner;

    logic       clk;
    logic       reset;
    logic [3:0] key_n;
    logic       repeat_en;
    logic [3:0] key_level;
    logic [3:0] key_press;
    logic [3:0] key_release;
    logic [3:0] key_repeat;
    logic       any_press;

    int vectors;
    int miscompares;

    key_conditioner #(
        .NUM_KEYS(4),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(10),
        .REPEAT_PERIOD(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .key_n(key_n),
        .repeat_en(repeat_en),
        .key_level(key_level),
        .key_press(key_press),
        .key_release(key_release),
        .key_repeat(key_repeat),
        .any_press(any_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and land on the following falling edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1; key_n = 4'b1111; repeat_en = 1'b1;
        tick(3);
        vectors++;
        if ({key_level, key_press, key_release, key_repeat, any_press} !== 17'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got %h want 0", {key_level, key_press, key_release, key_repeat, any_press});
        end
        reset = 1'b0;
        tick(8);
        vectors++;
        if (key_level !== 4'b0000) begin
            miscompares++;
            $display("FAIL idle_level got %b want 0000", key_level);
        end
    endtask

    task automatic test_clean_press;
        key_n[0] = 1'b0;
        tick(5);
        vectors++;
        if (key_level[0] !== 1'b0 || key_press[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL clean_early got level=%b press=%b want 0 0", key_level[0], key_press[0]);
        end
        tick(1);
        vectors++;
        if (key_level !== 4'b0001 || key_press !== 4'b0001 || any_press !== 1'b1) begin
            miscompares++;
            $display("FAIL clean_edge got level=%b press=%b any=%b want 0001 0001 1", key_level, key_press, any_press);
        end
        tick(1);
        vectors++;
        if (key_level[0] !== 1'b1 || key_press[0] !== 1'b0 || any_press !== 1'b0) begin
            miscompares++;
            $display("FAIL clean_after got level=%b press=%b any=%b want 1 0 0", key_level[0], key_press[0], any_press);
        end
        key_n[0] = 1'b1;
        tick(5);
        vectors++;
        if (key_release[0] !== 1'b0 || key_level[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL release_early got rel=%b level=%b want 0 1", key_release[0], key_level[0]);
        end
        tick(1);
        vectors++;
        if (key_release !== 4'b0001 || key_level[0] !== 1'b0 || key_repeat[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL release_edge got rel=%b level=%b rep=%b want 0001 0 0", key_release, key_level[0], key_repeat[0]);
        end
        tick(4);
    endtask

    task automatic test_bounce;
        int bad;
        bad = 0;
        for (int i = 0; i < 24; i++) begin
            key_n[1] = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
            tick(1);
            if (key_level[1] !== 1'b0 || key_press[1] !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL bounce_quiet got %0d disturbed cycles want 0", bad);
        end
        key_n[1] = 1'b0;
        tick(5);
        vectors++;
        if (key_press[1] !== 1'b0 || key_level[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL bounce_early got press=%b level=%b want 0 0", key_press[1], key_level[1]);
        end
        tick(1);
        vectors++;
        if (key_press !== 4'b0010 || key_level[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL bounce_press got press=%b level=%b want 0010 1", key_press, key_level[1]);
        end
        key_n[1] = 1'b1;
        tick(10);
    endtask

    task automatic test_auto_repeat;
        int bad;
        int releases;
        logic exp_rep;
        bad = 0; releases = 0;
        key_n[2] = 1'b0;
        tick(6);
        vectors++;
        if (key_press !== 4'b0100) begin
            miscompares++;
            $display("FAIL repeat_press got %b want 0100", key_press);
        end
        for (int t = 1; t <= 45; t++) begin
            tick(1);
            exp_rep = (t < 36) && (t >= 10) && ((t - 10) % 3 == 0);
            if (key_repeat[2] !== exp_rep) begin
                bad++;
                $display("FAIL repeat_tick t=%0d got %b want %b", t, key_repeat[2], exp_rep);
            end
            if (key_release[2] === 1'b1) releases++;
            if (t == 30) key_n[2] = 1'b1;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL repeat_train got %0d wrong cycles want 0", bad);
        end
        vectors++;
        if (releases != 1) begin
            miscompares++;
            $display("FAIL repeat_release got %0d releases want 1", releases);
        end
    endtask

    task automatic test_repeat_disable;
        int reps;
        int bad;
        logic exp_rep;
        reps = 0; bad = 0;
        repeat_en = 1'b0;
        key_n[3] = 1'b0;
        tick(6);
        vectors++;
        if (key_press !== 4'b1000) begin
            miscompares++;
            $display("FAIL dis_press got %b want 1000", key_press);
        end
        for (int t = 0; t < 20; t++) begin
            tick(1);
            if (key_repeat[3] === 1'b1) reps++;
        end
        vectors++;
        if (reps != 0) begin
            miscompares++;
            $display("FAIL dis_quiet got %0d repeats want 0", reps);
        end
        repeat_en = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            tick(1);
            exp_rep = ((t - 1) % 3 == 0);
            if (key_repeat[3] !== exp_rep) begin
                bad++;
                $display("FAIL dis_resume t=%0d got %b want %b", t, key_repeat[3], exp_rep);
            end
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL dis_resume_train got %0d wrong cycles want 0", bad);
        end
        key_n[3] = 1'b1;
        tick(10);
    endtask

    task automatic test_simultaneous;
        key_n[0] = 1'b0; key_n[3] = 1'b0;
        tick(5);
        vectors++;
        if (key_press !== 4'b0000 || any_press !== 1'b0) begin
            miscompares++;
            $display("FAIL sim_early got press=%b any=%b want 0000 0", key_press, any_press);
        end
        tick(1);
        vectors++;
        if (key_press !== 4'b1001 || any_press !== 1'b1) begin
            miscompares++;
            $display("FAIL sim_press got press=%b any=%b want 1001 1", key_press, any_press);
        end
        tick(1);
        vectors++;
        if (key_press !== 4'b0000 || any_press !== 1'b0 || key_level !== 4'b1001) begin
            miscompares++;
            $display("FAIL sim_after got press=%b any=%b level=%b want 0000 0 1001", key_press, any_press, key_level);
        end
        key_n[0] = 1'b1; key_n[3] = 1'b1;
        tick(10);
    endtask

    task automatic test_reset_mid_hold;
        int releases;
        releases = 0;
        key_n[1] = 1'b0;
        tick(6 + 12);
        vectors++;
        if (key_level[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL midhold_level got %b want 1", key_level[1]);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if ({key_level, key_press, key_release, key_repeat, any_press} !== 17'd0) begin
            miscompares++;
            $display("FAIL midhold_reset got %h want 0", {key_level, key_press, key_release, key_repeat, any_press});
        end
        tick(2);
        reset = 1'b0;
        for (int t = 1; t <= 6; t++) begin
            tick(1);
            if (key_release[1] === 1'b1) releases++;
            if (t == 5) begin
                vectors++;
                if (key_press[1] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL midhold_early got %b want 0", key_press[1]);
                end
            end
        end
        vectors++;
        if (key_press !== 4'b0010 || key_level[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL midhold_repress got press=%b level=%b want 0010 1", key_press, key_level[1]);
        end
        vectors++;
        if (releases != 0) begin
            miscompares++;
            $display("FAIL midhold_norelease got %0d want 0", releases);
        end
        key_n[1] = 1'b1;
        tick(10);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_repeat_disable();
        test_simultaneous();
        test_reset_mid_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
